fir_sample_feeder: RTL

- Upstream stage of the 64-tap FIR (16-bit in, 38-bit out). It buffers incoming 16-bit samples from a valid/ready stream in a small FIFO.
- It presents one sample at a time to the FIR: data held stable, input_valid pulsed for one cycle. It then waits for the FIR's output_valid rising edge before issuing the next sample.
- It replaces the hand-sequenced sample issue the bench currently does and adds a completion timeout.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/fir_sample_feeder.sv | 110 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR dimensions and sample-feeder state encoding
package fir_pkg;

  localparam int FIR_IN_WIDTH  = 16;
  localparam int FIR_OUT_WIDTH = 38;
  localparam int FIR_TAPS      = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } feeder_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - sample buffer with wrap-bit pointers; push refused when full,
// pop ignored when empty, read data is the registered head entry.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered pointers only, so a same-cycle pop never opens a slot.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - buffers upstream samples and issues them one at a time
// to the FIR, waiting for each result (or a timeout) before the next issue.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH     = FIR_IN_WIDTH,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         fir_input,
  output logic                          fir_input_valid,
  input  logic                          fir_output_valid,
  input  logic                          clear_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [CNT_WIDTH-1:0]          samples_done
);

  localparam int WAIT_W = idx_width(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_WIDTH-1:0] DONE_ONE = CNT_WIDTH'(1);

  feeder_state_t         state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  ovq;
  logic                  rise;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] head;

  assign s_ready = rst && !fifo_full;
  assign push    = s_valid && s_ready;
  assign pop     = (state == IDLE) && !fifo_empty;
  assign rise    = fir_output_valid && !ovq;
  assign busy    = (state != IDLE);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      fir_input       <= '0;
      fir_input_valid <= 1'b0;
      timeout_err     <= 1'b0;
      samples_done    <= '0;
      wait_cnt        <= '0;
      ovq             <= 1'b0;
    end else begin
      ovq             <= fir_output_valid;
      fir_input_valid <= 1'b0;
      // Clear first so a timeout later in this block overrides it.
      if (clear_err) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            fir_input       <= head;
            fir_input_valid <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          if (rise) begin
            samples_done <= samples_done + DONE_ONE;
            state        <= GAP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + WAIT_ONE;
          if (rise) begin
            samples_done <= samples_done + DONE_ONE;
            state        <= GAP;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
